// File: rtl/dnpcie_aurora_nfc_rx_gate.sv
// dnpcie_aurora_nfc_rx_gate
// Receive-side Aurora 8b10b native flow control handler. Decodes NFC
// messages from the core into a pause state (RUN / TPAUSE / XOFF) and gates
// the user TX AXI4-Stream into the core, only ever at frame boundaries.
// Everything runs in the user_clk domain with a synchronous active-low reset.
//
// Optional build macro: DNPCIE_NFC_RX_STATS_EN
//   When defined, adds xoff_events[15:0] (saturating count of pause entries
//   from RUN) and pause_cycles[31:0] (wrapping count of nfc_xoff=1 cycles).
//   Both counters are cleared by aresetn only, not by channel_up=0.
module dnpcie_aurora_nfc_rx_gate #(
    parameter int PAUSE_UNIT   = 8,
    parameter int XOFF_TIMEOUT = 65535
) (
    input  logic         user_clk,
    input  logic         aresetn,
    input  logic         channel_up,
    input  logic         rx_nfc_snf,
    input  logic [0:3]   rx_nfc_nb,
    input  logic [0:31]  s_axis_tx_tdata,
    input  logic [0:3]   s_axis_tx_tkeep,
    input  logic         s_axis_tx_tvalid,
    input  logic         s_axis_tx_tlast,
    output logic         s_axis_tx_tready,
    output logic [0:31]  m_axis_tx_tdata,
    output logic [0:3]   m_axis_tx_tkeep,
    output logic         m_axis_tx_tvalid,
    output logic         m_axis_tx_tlast,
    input  logic         m_axis_tx_tready,
    output logic         nfc_xoff,
    output logic         xoff_timeout
`ifdef DNPCIE_NFC_RX_STATS_EN
    ,
    output logic [15:0]  xoff_events,
    output logic [31:0]  pause_cycles
`endif
);

    // Pause counter must hold the largest timed pause, 14 * PAUSE_UNIT.
    localparam int PCW = $clog2(14 * PAUSE_UNIT + 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_TPAUSE = 2'd1;
    localparam logic [1:0] ST_XOFF   = 2'd2;

    // XOFF_TIMEOUT == 0 means XOFF is held until an explicit XON.
    localparam bit          TO_EN   = (XOFF_TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(XOFF_TIMEOUT - 1) : 16'd0;

    logic [1:0]     state_q, state_d;
    logic [PCW-1:0] pause_cnt_q, pause_cnt_d;
    logic [15:0]    to_cnt_q, to_cnt_d;
    logic           in_frame_q, in_frame_d;
    logic           nfc_xoff_q, nfc_xoff_d;
    logic           xoff_timeout_q, xoff_timeout_d;
    logic           block;
    logic           beat_accept;

    // Gate: only closes between frames, so a started frame always completes.
    assign block            = nfc_xoff_q & ~in_frame_q;
    assign m_axis_tx_tvalid = s_axis_tx_tvalid & ~block;
    assign s_axis_tx_tready = m_axis_tx_tready & ~block & channel_up;
    assign m_axis_tx_tdata  = s_axis_tx_tdata;
    assign m_axis_tx_tkeep  = s_axis_tx_tkeep;
    assign m_axis_tx_tlast  = s_axis_tx_tlast;
    assign beat_accept      = s_axis_tx_tvalid & s_axis_tx_tready;

    assign nfc_xoff     = nfc_xoff_q;
    assign xoff_timeout = xoff_timeout_q;

    // NFC decode and pause/XOFF timing; link-down overrides any strobe.
    always_comb begin
        state_d        = state_q;
        pause_cnt_d    = pause_cnt_q;
        to_cnt_d       = to_cnt_q;
        xoff_timeout_d = 1'b0;
        if (!channel_up) begin
            state_d     = ST_RUN;
            pause_cnt_d = '0;
            to_cnt_d    = '0;
        end else if (rx_nfc_snf) begin
            // The latest message always wins, whatever the current state.
            if (rx_nfc_nb == 4'd0) begin
                state_d     = ST_RUN;
                pause_cnt_d = '0;
            end else if (rx_nfc_nb == 4'd15) begin
                state_d  = ST_XOFF;
                to_cnt_d = '0;
            end else begin
                state_d     = ST_TPAUSE;
                pause_cnt_d = PCW'(int'(rx_nfc_nb) * PAUSE_UNIT);
            end
        end else begin
            case (state_q)
                ST_TPAUSE: begin
                    // Leaving on the count==1 edge gives exactly nb*PAUSE_UNIT
                    // cycles of nfc_xoff.
                    if (pause_cnt_q <= PCW'(1)) begin
                        state_d     = ST_RUN;
                        pause_cnt_d = '0;
                    end else begin
                        pause_cnt_d = pause_cnt_q - PCW'(1);
                    end
                end
                ST_XOFF: begin
                    if (to_cnt_q != 16'hFFFF) begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                    if (TO_EN && (to_cnt_q == TO_LAST)) begin
                        state_d        = ST_RUN;
                        to_cnt_d       = '0;
                        xoff_timeout_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // nfc_xoff is registered alongside the state so it mirrors state != RUN.
    always_comb begin
        nfc_xoff_d = (state_d != ST_RUN);
    end

    // Frame tracking: in_frame is high between an accepted non-last beat and
    // the accepted tlast beat.
    always_comb begin
        in_frame_d = in_frame_q;
        if (!channel_up) begin
            in_frame_d = 1'b0;
        end else if (beat_accept) begin
            in_frame_d = ~s_axis_tx_tlast;
        end
    end

    // Control state registers.
    always_ff @(posedge user_clk) begin
        if (!aresetn) begin
            state_q        <= ST_RUN;
            pause_cnt_q    <= '0;
            to_cnt_q       <= '0;
            in_frame_q     <= 1'b0;
            nfc_xoff_q     <= 1'b0;
            xoff_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pause_cnt_q    <= pause_cnt_d;
            to_cnt_q       <= to_cnt_d;
            in_frame_q     <= in_frame_d;
            nfc_xoff_q     <= nfc_xoff_d;
            xoff_timeout_q <= xoff_timeout_d;
        end
    end

`ifdef DNPCIE_NFC_RX_STATS_EN
    logic [15:0] xoff_events_q, xoff_events_d;
    logic [31:0] pause_cycles_q, pause_cycles_d;

    assign xoff_events  = xoff_events_q;
    assign pause_cycles = pause_cycles_q;

    // Statistics: pause entries from RUN (saturating) and paused cycles (wrapping).
    always_comb begin
        xoff_events_d  = xoff_events_q;
        pause_cycles_d = pause_cycles_q;
        if ((state_q == ST_RUN) && (state_d != ST_RUN) && (xoff_events_q != 16'hFFFF)) begin
            xoff_events_d = xoff_events_q + 16'd1;
        end
        if (nfc_xoff_q) begin
            pause_cycles_d = pause_cycles_q + 32'd1;
        end
    end

    // Statistics registers; cleared by aresetn only.
    always_ff @(posedge user_clk) begin
        if (!aresetn) begin
            xoff_events_q  <= '0;
            pause_cycles_q <= '0;
        end else begin
            xoff_events_q  <= xoff_events_d;
            pause_cycles_q <= pause_cycles_d;
        end
    end
`else
    // Statistics disabled: no counters and no extra ports in this build.
`endif

endmodule

// File: tb/tb_dnpcie_aurora_nfc_rx_gate.sv
// Directed bench for dnpcie_aurora_nfc_rx_gate (PAUSE_UNIT=8, XOFF_TIMEOUT=100).
// Statistics checks are included when DNPCIE_NFC_RX_STATS_EN is defined.
module tb_dnpcie_aurora_nfc_rx_gate;

    logic         user_clk = 1'b0;
    logic         aresetn;
    logic         channel_up;
    logic         rx_nfc_snf;
    logic [0:3]   rx_nfc_nb;
    logic [0:31]  s_tdata;
    logic [0:3]   s_tkeep;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [0:31]  m_tdata;
    logic [0:3]   m_tkeep;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic         nfc_xoff;
    logic         xoff_timeout;
`ifdef DNPCIE_NFC_RX_STATS_EN
    logic [15:0]  xoff_events;
    logic [31:0]  pause_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 user_clk = ~user_clk;

    dnpcie_aurora_nfc_rx_gate #(
        .PAUSE_UNIT   (8),
        .XOFF_TIMEOUT (100)
    ) dut (
        .user_clk         (user_clk),
        .aresetn          (aresetn),
        .channel_up       (channel_up),
        .rx_nfc_snf       (rx_nfc_snf),
        .rx_nfc_nb        (rx_nfc_nb),
        .s_axis_tx_tdata  (s_tdata),
        .s_axis_tx_tkeep  (s_tkeep),
        .s_axis_tx_tvalid (s_tvalid),
        .s_axis_tx_tlast  (s_tlast),
        .s_axis_tx_tready (s_tready),
        .m_axis_tx_tdata  (m_tdata),
        .m_axis_tx_tkeep  (m_tkeep),
        .m_axis_tx_tvalid (m_tvalid),
        .m_axis_tx_tlast  (m_tlast),
        .m_axis_tx_tready (m_tready),
        .nfc_xoff         (nfc_xoff),
        .xoff_timeout     (xoff_timeout)
`ifdef DNPCIE_NFC_RX_STATS_EN
        ,
        .xoff_events      (xoff_events),
        .pause_cycles     (pause_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn    = 1'b0;
        channel_up = 1'b1;
        rx_nfc_snf = 1'b0;
        rx_nfc_nb  = 4'd0;
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;

        // ---- Reset state ----
        repeat (3) step();
        settle();
        chk("rst_xoff", 32'(nfc_xoff), 32'd0);
        chk("rst_to", 32'(xoff_timeout), 32'd0);
        aresetn = 1'b1;
        step();
        settle();
        chk("rst_tready", 32'(s_tready), 32'd1);
        $display("reset released");

        // ---- Test 1: three 4-beat frames pass unmodified, zero latency ----
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 4; b++) begin
                step();
                s_tvalid = 1'b1;
                s_tdata  = 32'hA000_0000 + 32'(f * 16 + b);
                s_tkeep  = 4'hF - 4'(b);
                s_tlast  = (b == 3);
                settle();
                chk("t1_mvalid", 32'(m_tvalid), 32'd1);
                chk("t1_tready", 32'(s_tready), 32'd1);
                chk("t1_data", 32'(m_tdata), 32'hA000_0000 + 32'(f * 16 + b));
                chk("t1_keep", 32'(m_tkeep), 32'(4'hF - 4'(b)));
                chk("t1_last", 32'(m_tlast), 32'(b == 3));
                chk("t1_xoff", 32'(nfc_xoff), 32'd0);
                $display("t1 frame %0d beat %0d data %08h", f, b, m_tdata);
            end
        end
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        // ---- Test 2: idle, timed pause nb=2 -> 16 cycles of nfc_xoff ----
        step();
        rx_nfc_snf = 1'b1;
        rx_nfc_nb  = 4'd2;
        settle();
        chk("t2_pre_xoff", 32'(nfc_xoff), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 0) begin
                rx_nfc_snf = 1'b0;
                s_tvalid   = 1'b1;
                s_tdata    = 32'hB0B0_0001;
                s_tkeep    = 4'hF;
                s_tlast    = 1'b1;
            end
            settle();
            chk("t2_xoff", 32'(nfc_xoff), 32'd1);
            chk("t2_mvalid", 32'(m_tvalid), 32'd0);
            chk("t2_tready", 32'(s_tready), 32'd0);
        end
        step();
        settle();
        chk("t2_rel_xoff", 32'(nfc_xoff), 32'd0);
        chk("t2_rel_mvalid", 32'(m_tvalid), 32'd1);
        chk("t2_rel_tready", 32'(s_tready), 32'd1);
        $display("t2 beat accepted after release data %08h", m_tdata);
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        // ---- Test 3: XOFF at beat 2 of an 8-beat frame, XON 50 cycles later ----
        step();
        s_tvalid = 1'b1;
        s_tdata  = 32'hC000_0000;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b0;
        settle();
        chk("t3_b1_tready", 32'(s_tready), 32'd1);
        step();
        s_tdata    = 32'hC000_0001;
        rx_nfc_snf = 1'b1;
        rx_nfc_nb  = 4'd15;
        settle();
        chk("t3_b2_tready", 32'(s_tready), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            rx_nfc_snf = 1'b0;
            s_tdata    = 32'hC000_0001 + 32'(k);
            s_tlast    = (k == 6);
            settle();
            chk("t3_mid_xoff", 32'(nfc_xoff), 32'd1);
            chk("t3_mid_mvalid", 32'(m_tvalid), 32'd1);
            chk("t3_mid_tready", 32'(s_tready), 32'd1);
            $display("t3 beat %0d passes during xoff data %08h", k + 2, m_tdata);
        end
        for (int k = 7; k <= 50; k++) begin
            step();
            s_tdata = 32'hD000_0000;
            s_tlast = 1'b0;
            if (k == 50) begin
                rx_nfc_snf = 1'b1;
                rx_nfc_nb  = 4'd0;
            end
            settle();
            chk("t3_hold_xoff", 32'(nfc_xoff), 32'd1);
            chk("t3_hold_mvalid", 32'(m_tvalid), 32'd0);
            chk("t3_hold_tready", 32'(s_tready), 32'd0);
        end
        step();
        rx_nfc_snf = 1'b0;
        settle();
        chk("t3_rel_xoff", 32'(nfc_xoff), 32'd0);
        chk("t3_rel_mvalid", 32'(m_tvalid), 32'd1);
        chk("t3_rel_tready", 32'(s_tready), 32'd1);
        $display("t3 next frame resumes data %08h", m_tdata);
        step();
        s_tdata = 32'hD000_0001;
        s_tlast = 1'b1;
        settle();
        chk("t3_end_tready", 32'(s_tready), 32'd1);
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        settle();
`ifdef DNPCIE_NFC_RX_STATS_EN
        chk("t6_xoff_events", 32'(xoff_events), 32'd2);
        chk("t6_pause_cycles", pause_cycles, 32'd66);
        $display("t6 stats events %0d cycles %0d", xoff_events, pause_cycles);
`endif

        // ---- Test 4: XOFF with no XON -> forced release after 100 cycles ----
        step();
        rx_nfc_snf = 1'b1;
        rx_nfc_nb  = 4'd15;
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 0) begin
                rx_nfc_snf = 1'b0;
                s_tvalid   = 1'b1;
                s_tdata    = 32'hE000_0000;
                s_tlast    = 1'b1;
            end
            settle();
            chk("t4_xoff", 32'(nfc_xoff), 32'd1);
            chk("t4_pulse", 32'(xoff_timeout), 32'd0);
        end
        step();
        settle();
        chk("t4_rel_xoff", 32'(nfc_xoff), 32'd0);
        chk("t4_rel_pulse", 32'(xoff_timeout), 32'd1);
        chk("t4_rel_mvalid", 32'(m_tvalid), 32'd1);
        $display("t4 forced release, beat passes data %08h", m_tdata);
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        settle();
        chk("t4_pulse_end", 32'(xoff_timeout), 32'd0);

        // ---- Test 5: reload TPAUSE 14 -> 1, then link down beats XOFF strobe ----
        step();
        rx_nfc_snf = 1'b1;
        rx_nfc_nb  = 4'd14;
        step();
        rx_nfc_snf = 1'b0;
        repeat (5) step();
        rx_nfc_snf = 1'b1;
        rx_nfc_nb  = 4'd1;
        for (int i = 0; i < 8; i++) begin
            step();
            rx_nfc_snf = 1'b0;
            settle();
            chk("t5_reload_xoff", 32'(nfc_xoff), 32'd1);
        end
        step();
        settle();
        chk("t5_reload_end", 32'(nfc_xoff), 32'd0);
        $display("t5 reload to 8 cycles observed");
        step();
        rx_nfc_snf = 1'b1;
        rx_nfc_nb  = 4'd14;
        step();
        rx_nfc_snf = 1'b0;
        step();
        settle();
        chk("t5_pre_down_xoff", 32'(nfc_xoff), 32'd1);
        channel_up = 1'b0;
        rx_nfc_snf = 1'b1;
        rx_nfc_nb  = 4'd15;
        s_tvalid   = 1'b1;
        s_tlast    = 1'b1;
        step();
        rx_nfc_snf = 1'b0;
        settle();
        chk("t5_down_xoff", 32'(nfc_xoff), 32'd0);
        chk("t5_down_tready", 32'(s_tready), 32'd0);
        step();
        settle();
        chk("t5_down2_tready", 32'(s_tready), 32'd0);
        channel_up = 1'b1;
        settle();
        chk("t5_up_tready", 32'(s_tready), 32'd1);
        chk("t5_up_xoff", 32'(nfc_xoff), 32'd0);
        $display("t5 link down forced RUN, link restored");
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
